seq_pattern_gen: RTL
====================

// Module: seq_pattern_gen
// PURPOSE
//  Serial pattern transmitter: the companion to the team's serial sequence detector.
//  Shifts a programmable bit pattern MSB-first onto a 1-bit serial line (x).
//  Can repeat the pattern a programmed number of times, with optional idle gap bits.
//  Drives detector test benches and link bring-up stimulus in the same clock domain.
// PARAMETERS
//  PAT_W     8  max pattern length in bits; pattern register width
//  CNT_W     8  width of repeat counter
//  GAP_BITS  0  idle bits (x=0, x_valid=0) inserted between repetitions; 0 = back-to-back
// PORTS
//  clk        input   1                  rising-edge clock
//  reset      input   1                  asynchronous, active-low reset
//  start      input   1                  request a transmission; sampled only in IDLE
//  pattern    input   PAT_W              bits to send; bit [len-1] is sent first
//  pat_len    input   $clog2(PAT_W+1)    number of bits per repetition
//  rep_cnt    input   CNT_W              repetitions; 0 = continuous until stop
//  stop       input   1                  graceful stop request
//  x          output  1                  serial data bit (registered)
//  x_valid    output  1                  x carries a pattern bit this cycle
//  busy       output  1                  high from the cycle after start until done
//  done       output  1                  one-cycle pulse at end of transmission
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; x=0, x_valid=0, busy=0, done=0; counters cleared.
//  All outputs are registered; no combinational input->output path.
//  FSM states: IDLE, SHIFT, GAP, DONE.
//   IDLE:  start=1 -> latch pattern, len, rep_cnt into shadow registers -> SHIFT.
//          A latched len of 0 or >PAT_W is clamped to PAT_W.
//          Inputs may change freely after this cycle.
//   SHIFT: each cycle drives x=shadow[bit_idx], x_valid=1, busy=1.
//          bit_idx runs from len-1 down to 0.
//          After bit 0, a repetition is complete:
//           - If the last repetition is done (reps_sent+1==rep_cnt, rep_cnt!=0),
//             or the stop flag is set -> DONE.
//           - Otherwise -> GAP (if GAP_BITS>0) or reload bit_idx=len-1 and stay in SHIFT.
//   GAP:   drives x=0, x_valid=0, busy=1 for exactly GAP_BITS cycles.
//          Then -> SHIFT with bit_idx=len-1.
//   DONE:  done=1 and busy=0 for one cycle; x=0, x_valid=0. Next state IDLE.
//  Latency: start sampled at edge N -> first bit valid on x after edge N+1.
//   A single repetition of L bits occupies edges N+1..N+L; done is high after edge N+L+1.
//  start: ignored outside IDLE, including in the DONE cycle.
//   A new start may be accepted in the first IDLE cycle.
//  stop: sets a sticky flag; the current repetition always completes (no truncated pattern).
//   The flag is cleared on entry to IDLE. stop in IDLE has no effect.
//   stop during GAP -> GAP finishes, one further full repetition, then DONE.
//  rep_cnt=0: repeats indefinitely until stop. The reps_sent counter wraps at 2^CNT_W
//   with no side effect.
//  Overlapping patterns and GAP_BITS=0 produce a continuous stream, so a downstream
//   overlapping detector must see every boundary.
//  Reset mid-transmission: outputs are forced to reset values immediately (async).
//   No done pulse is generated.
// TESTING
//  1 pattern=8'h15, pat_len=5, rep_cnt=1, start 1 cycle -> x=1,0,1,0,1 with x_valid=1 on
//    5 consecutive cycles; done pulse on the 6th cycle; busy high for exactly 5 cycles.
//  2 Same pattern, rep_cnt=3, GAP_BITS=0 -> 15 valid bits (10101 x3) with no x_valid gap;
//    exactly one done pulse.
//  3 GAP_BITS=2, rep_cnt=2 -> 10101, two cycles x_valid=0, 10101, then done.
//  4 rep_cnt=0 with stop pulsed at bit 2 of rep 4 -> rep 4 completes fully, then done;
//    total of 20 valid bits.
//  5 reset asserted mid-SHIFT -> x, x_valid, busy and done go 0 the same cycle;
//    after release, start works normally.
//  6 pat_len=0 -> transmits all 8 bits; start re-asserted while busy -> ignored.
//    Loopback into the detector (pattern 101011) -> detector z=1 exactly once per repetition.

Source files
------------

// File: rtl/seq_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen_if
//   Request/stream bundle for the serial pattern transmitter.
//   master : the requester (drives start/pattern/pat_len/rep_cnt/stop, sees line)
//   slave  : the transmitter (drives x/x_valid/busy/done)
// Signals
//   start    request a transmission
//   pattern  bits to send, bit [len-1] first
//   pat_len  bits per repetition (0 or >PAT_W means PAT_W)
//   rep_cnt  repetitions, 0 = continuous until stop
//   stop     graceful stop request
//   x        serial data bit
//   x_valid  x carries a pattern bit
//   busy     transmission in progress
//   done     one-cycle end-of-transmission pulse
// -----------------------------------------------------------------------------
interface seq_pattern_gen_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) ();
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] rep_cnt;
  logic             stop;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, pat_len, rep_cnt, stop,
    input  x, x_valid, busy, done
  );

  modport slave (
    input  start, pattern, pat_len, rep_cnt, stop,
    output x, x_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen.sv
// -----------------------------------------------------------------------------
// seq_pattern_gen
//   Serial pattern transmitter. Shifts a latched pattern MSB-first onto x,
//   repeating it rep_cnt times (0 = until stop) with GAP_BITS idle cycles
//   between repetitions. All outputs are registered.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    seq_pattern_gen_if.slave (request inputs, serial line outputs)
// -----------------------------------------------------------------------------
module seq_pattern_gen #(
  parameter int PAT_W    = 8,
  parameter int CNT_W    = 8,
  parameter int GAP_BITS = 0
) (
  input  logic                clk,
  input  logic                reset,
  seq_pattern_gen_if.slave    bus
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam bit HAS_GAP = (GAP_BITS > 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [PAT_W-1:0] shadow_r;
  logic [LEN_W-1:0] len_r;
  logic [CNT_W-1:0] rep_cnt_r;
  logic [CNT_W-1:0] reps_sent_r;
  logic [IDX_W-1:0] bit_idx_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             stop_r;
  logic             x_r;
  logic             x_valid_r;
  logic             busy_r;
  logic             done_r;

  logic [LEN_W-1:0] len_clamp_s;
  logic [IDX_W-1:0] start_idx_s;
  logic [IDX_W-1:0] reload_idx_s;
  logic [CNT_W-1:0] next_reps_s;
  logic             last_rep_s;
  logic             stop_seen_s;

  // Length clamping, repetition bookkeeping and stop visibility
  always_comb begin
    len_clamp_s  = bus.pat_len;
    if ((bus.pat_len == LEN_W'(0)) || (bus.pat_len > LEN_W'(PAT_W))) begin
      len_clamp_s = LEN_W'(PAT_W);
    end else begin
      len_clamp_s = bus.pat_len;
    end
    start_idx_s  = IDX_W'(len_clamp_s - LEN_W'(1));
    reload_idx_s = IDX_W'(len_r - LEN_W'(1));
    next_reps_s  = reps_sent_r + CNT_W'(1);
    // rep_cnt of zero never matches: run until stop. reps_sent wraps harmlessly.
    last_rep_s   = (rep_cnt_r != CNT_W'(0)) && (next_reps_s == rep_cnt_r);
    // A stop arriving on the final bit still ends the run after this repetition.
    stop_seen_s  = stop_r | bus.stop;
  end

  // Transmit FSM; outputs reflect the state being left at each edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      shadow_r    <= '0;
      len_r       <= '0;
      rep_cnt_r   <= '0;
      reps_sent_r <= '0;
      bit_idx_r   <= '0;
      gap_cnt_r   <= '0;
      stop_r      <= 1'b0;
      x_r         <= 1'b0;
      x_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          x_r       <= 1'b0;
          x_valid_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          stop_r    <= 1'b0;
          if (bus.start) begin
            shadow_r    <= bus.pattern;
            len_r       <= len_clamp_s;
            rep_cnt_r   <= bus.rep_cnt;
            reps_sent_r <= '0;
            bit_idx_r   <= start_idx_s;
            gap_cnt_r   <= '0;
            state_r     <= ST_SHIFT;
          end else begin
            state_r     <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          x_r       <= shadow_r[bit_idx_r];
          x_valid_r <= 1'b1;
          busy_r    <= 1'b1;
          done_r    <= 1'b0;
          if (bus.stop) begin
            stop_r <= 1'b1;
          end else begin
            stop_r <= stop_r;
          end
          if (bit_idx_r == IDX_W'(0)) begin
            reps_sent_r <= next_reps_s;
            if (last_rep_s || stop_seen_s) begin
              state_r <= ST_DONE;
            end else if (HAS_GAP) begin
              gap_cnt_r <= '0;
              state_r   <= ST_GAP;
            end else begin
              bit_idx_r <= reload_idx_s;
              state_r   <= ST_SHIFT;
            end
          end else begin
            bit_idx_r <= bit_idx_r - IDX_W'(1);
            state_r   <= ST_SHIFT;
          end
        end

        ST_GAP: begin
          x_r       <= 1'b0;
          x_valid_r <= 1'b0;
          busy_r    <= 1'b1;
          done_r    <= 1'b0;
          if (bus.stop) begin
            stop_r <= 1'b1;
          end else begin
            stop_r <= stop_r;
          end
          if (gap_cnt_r == GAP_LAST) begin
            bit_idx_r <= reload_idx_s;
            state_r   <= ST_SHIFT;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            state_r   <= ST_GAP;
          end
        end

        ST_DONE: begin
          x_r       <= 1'b0;
          x_valid_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b1;
          stop_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end

        default: begin
          x_r       <= 1'b0;
          x_valid_r <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          stop_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.x       = x_r;
  assign bus.x_valid = x_valid_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule
